// File: rtl/cp0_exc_ctrl_if.sv
// M-stage coprocessor-0 bus: mfc0/mtc0 access, exception inputs and the
// interrupt request/redirect back to the pipeline.
interface cp0_exc_ctrl_if;
  logic        we;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        int_req;
  logic [31:0] handler_pc;

  modport master (
    output we, a1, a2, din, pc, bd, exc_code, hw_int, eret,
    input  dout, epc_out, int_req, handler_pc
  );

  modport slave (
    input  we, a1, a2, din, pc, bd, exc_code, hw_int, eret,
    output dout, epc_out, int_req, handler_pc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: holds SR/Cause/EPC, decides
// exception entry in the M stage and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h4B4E_0700
) (
  input logic         clk,
  input logic         reset,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        irq_c;
  logic        exc_c;
  logic        take_c;
  logic [31:0] epc_entry_c;
  logic [31:0] sr_word_c;
  logic [31:0] cause_word_c;
  logic [31:0] dout_c;

  assign irq_c  = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_c  = (bus.exc_code != 5'd0) & ~sr_exl;
  assign take_c = irq_c | exc_c;

  // A delay-slot instruction restarts at its branch.
  assign epc_entry_c = (bus.bd ? (bus.pc - 32'd4) : bus.pc) & ~32'h3;

  assign sr_word_c    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word_c = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

  always_comb begin
    dout_c = 32'd0;
    case (bus.a1)
      REG_SR:    dout_c = sr_word_c;
      REG_CAUSE: dout_c = cause_word_c;
      REG_EPC:   dout_c = epc;
      REG_PRID:  dout_c = PRID;
      default:   dout_c = 32'd0;
    endcase
  end

  assign bus.dout       = dout_c;
  assign bus.epc_out    = epc;
  assign bus.int_req    = take_c;
  assign bus.handler_pc = HANDLER_ADDR;

  // Exception entry discards mtc0/eret; otherwise eret's EXL clear overrides mtc0 SR.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= bus.hw_int;
      if (take_c) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.bd;
        cause_exc <= irq_c ? 5'd0 : bus.exc_code;
        epc       <= epc_entry_c;
      end else begin
        if (bus.we && (bus.a2 == REG_SR)) begin
          sr_im  <= bus.din[15:10];
          sr_exl <= bus.din[1];
          sr_ie  <= bus.din[0];
        end
        if (bus.we && (bus.a2 == REG_EPC)) begin
          epc <= bus.din & ~32'h3;
        end
        if (bus.eret) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus randomized traffic checked
// against a register-word reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID_V  = 32'h4B4E_0700;

  logic clk;
  logic reset;
  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(.HANDLER_ADDR(HANDLER), .PRID(PRID_V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model keeps whole architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  function automatic logic m_irq();
    return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_take();
    return m_irq() || ((bus.exc_code != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge();
    logic [31:0] ip_word;
    ip_word = 32'(bus.hw_int) << 10;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (m_take()) begin
      m_cause = (32'(bus.bd) << 31) | ip_word | (m_irq() ? 32'd0 : (32'(bus.exc_code) << 2));
      m_epc   = (bus.bd ? bus.pc - 4 : bus.pc) & ~32'h3;
      m_sr    = m_sr | 32'h2;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ip_word;
      if (bus.we && bus.a2 == 5'd12) m_sr  = bus.din & 32'h0000_FC03;
      if (bus.we && bus.a2 == 5'd14) m_epc = bus.din & ~32'h3;
      if (bus.eret)                  m_sr  = m_sr & ~32'h2;
    end
  endtask

  // One clock: compare combinational outputs mid-cycle, then advance the model.
  task automatic tick();
    @(negedge clk);
    check("int_req", 32'(bus.int_req), 32'(m_take()));
    check("dout", bus.dout, m_read(bus.a1));
    check("epc_out", bus.epc_out, m_epc);
    check("handler_pc", bus.handler_pc, HANDLER);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.a1 = 0; bus.a2 = 0; bus.din = 0; bus.pc = 0;
    bus.bd = 0; bus.exc_code = 0; bus.hw_int = 0; bus.eret = 0;
  endtask

  task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
    bus.a1 = r;
    #1;
    check(tag, bus.dout, exp);
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1;
    idle_inputs();
    @(posedge clk); #1;
    tick();
    reset = 0;
    tick();

    // Reset state
    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    peek("rst_prid", 5'd15, PRID_V);
    check("rst_int_req", 32'(bus.int_req), 32'd0);

    // Enabled interrupt
    bus.we = 1; bus.a2 = 5'd12; bus.din = 32'h0000_FC01;
    tick();
    bus.we = 0; bus.hw_int = 6'b000100; bus.pc = 32'h0000_1000;
    #1 check("irq_same_cycle", 32'(bus.int_req), 32'd1);
    tick();
    bus.hw_int = 0;
    peek("irq_sr", 5'd12, 32'h0000_FC03);
    peek("irq_cause", 5'd13, 32'h0000_1000);
    peek("irq_epc", 5'd14, 32'h0000_1000);

    // Nested events ignored while EXL=1, then eret re-opens a pending irq
    bus.exc_code = 5'd10; bus.hw_int = 6'h3F; bus.pc = 32'h0000_2000;
    #1 check("exl_masks", 32'(bus.int_req), 32'd0);
    tick();
    check("exl_epc_held", bus.epc_out, 32'h0000_1000);
    bus.eret = 1;
    tick();
    bus.eret = 0; bus.exc_code = 0;
    #1 check("eret_reopens_irq", 32'(bus.int_req), 32'd1);
    tick();
    check("reentry_epc", bus.epc_out, 32'h0000_2000);
    bus.hw_int = 0; bus.eret = 1;
    tick();
    bus.eret = 0;

    // Synchronous exception in a delay slot
    bus.exc_code = 5'd12; bus.pc = 32'h0000_3010; bus.bd = 1;
    #1 check("exc_same_cycle", 32'(bus.int_req), 32'd1);
    tick();
    bus.exc_code = 0; bus.bd = 0;
    peek("exc_cause", 5'd13, 32'h8000_0030);
    check("exc_epc", bus.epc_out, 32'h0000_300C);
    bus.eret = 1;
    tick();
    bus.eret = 0;

    // Interrupt beats exception; mtc0 EPC in the same cycle is dropped
    bus.hw_int = 6'b000100; bus.exc_code = 5'd4; bus.pc = 32'h0000_4000;
    bus.we = 1; bus.a2 = 5'd14; bus.din = 32'hDEAD_0000;
    tick();
    bus.we = 0; bus.exc_code = 0; bus.hw_int = 0;
    peek("prio_cause", 5'd13, 32'h0000_1000);
    check("prio_epc", bus.epc_out, 32'h0000_4000);

    // Reset in the middle of a handler
    reset = 1;
    tick();
    reset = 0;
    peek("midrst_sr", 5'd12, 32'd0);
    peek("midrst_cause", 5'd13, 32'd0);
    check("midrst_epc", bus.epc_out, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) < 2);
      bus.we       = ($urandom_range(0, 3) == 0);
      bus.a2       = 5'($urandom_range(10, 16));
      bus.a1       = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(11, 16)) : 5'($urandom);
      bus.din      = $urandom;
      bus.pc       = $urandom;
      bus.bd       = 1'($urandom);
      bus.exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      bus.hw_int   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      bus.eret     = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
